multicycle_ctrl_fsm: RTL
========================

// Module: multicycle_ctrl_fsm
// PURPOSE
//  Multi-cycle control unit for the R3000 core: decodes the same opcode set as the single-cycle decoder,
//  sequences FETCH/DECODE/EXEC/MEM/WB per instruction, and stalls on a memory ready handshake.
//  Adds a wait timeout, an illegal-opcode trap and a retired-instruction counter.
//  Sits between the instruction register/memory port and the shared single-ALU datapath.
// PARAMETERS
//  ALU_OP_W   5    width of alu_op_o; ALU codes below are zero-extended to it
//  TIMEOUT    255  max consecutive cycles with mem_ready_i low in FETCH/MEM before trapping (>=1)
//  CNT_W      32   width of instr_cnt_o
// PORTS
//  clk_i         in   1         clock, rising edge
//  rst_n_i       in   1         asynchronous, active-low reset
//  run_i         in   1         1 = keep issuing instructions; sampled only in IDLE and at instruction end
//  clr_i         in   1         leave TRAP, clear sticky flags
//  instr_op_i    in   6         opcode field of IR, valid from DECODE onward
//  mem_ready_i   in   1         memory completes current read/write this cycle
//  pc_write_o    out  1         load PC (PC+4 in FETCH; jump target in EXEC)
//  ir_write_o    out  1         load IR
//  i_or_d_o      out  1         memory address: 0 = PC, 1 = ALUOut
//  mem_read_o    out  1         memory read request
//  mem_write_o   out  1         memory write request
//  reg_write_o   out  1         register-file write
//  reg_dst_o     out  1         1 = rd, 0 = rt
//  mem_to_reg_o  out  1         1 = write back MDR
//  link_o        out  1         write PC into $31 (JAL)
//  alu_src_a_o   out  1         0 = PC, 1 = rs
//  alu_src_b_o   out  2         00 = rt, 01 = const 4, 10 = imm
//  alu_op_o      out  ALU_OP_W  NOTH=00 ADD=01 ADDU=02 AND=04 OR=05 NOR=07 SLT=09 EQ=0D NEQ=0E GT=0F JTYP=10 LUI=11
//  branch_o      out  1         conditional PC write if ALU condition is true
//  jump_o        out  1         unconditional PC write of jump target
//  mem_num_o     out  2         01 = byte, 10 = half, 11 = word
//  unsigned_o    out  1         zero-extend load data / immediate
//  state_o       out  3         IDLE=0 FETCH=1 DECODE=2 EXEC=3 MEM=4 WB=5 TRAP=6
//  instr_done_o  out  1         1-cycle pulse: instruction retires
//  illegal_o     out  1         sticky: undefined opcode
//  timeout_o     out  1         sticky: memory wait exceeded TIMEOUT
//  instr_cnt_o   out  CNT_W     retired-instruction count
// BEHAVIOUR
//  - Reset (async assert, sync release): state IDLE; opcode latch, wait counter, flags and instr_cnt_o = 0.
//    All control outputs 0; they are Moore (decoded from state + latched opcode), except FETCH ir_write/pc_write.
//  - IDLE: goes to FETCH when run_i = 1.
//  - FETCH: mem_read=1, i_or_d=0, src_a=0, src_b=01, alu_op=ADDU.
//    On mem_ready_i: ir_write=pc_write=1 in that same cycle, then DECODE.
//  - DECODE: latch instr_op_i. Undefined opcode -> TRAP and set illegal_o. Otherwise -> EXEC.
//  - EXEC: src_a=1, opcode-specific per-opcode decode table, then:
//    R-type (00): src_b=00, reg_dst=1, alu_op=NOTH -> WB.
//    ADDI/ADDIU/ANDI/ORI/NORI/SLTI/LUI (08/09/0C/0D/0E/0A/0F): src_b=10, alu_op ADD/ADDU/AND/OR/NOR/SLT/LUI -> WB.
//      unsigned_o=1 for ADDIU only.
//    Loads/stores LW23 LH21 LHU25 LB20 LBU24 SW2B SH29 SB28: src_b=10, alu_op=ADD -> MEM.
//      mem_num and unsigned as in the size table; unsigned_o=1 only for LHU/LBU.
//    BEQ04/BNE05/BGTZ07: src_b=00, branch_o=1, alu_op EQ/NEQ/GT; instruction done.
//    J02: jump_o=pc_write=1, alu_op=JTYP; done. JAL03: same -> WB.
//  - MEM: i_or_d=1; loads assert mem_read, stores assert mem_write; mem_num/unsigned held.
//    Wait for mem_ready_i: loads -> WB, stores done.
//  - WB: reg_write=1; mem_to_reg=1 for loads; reg_dst=1 for R-type; link_o=1 for JAL; done.
//  - Done: instr_done_o=1 and instr_cnt_o+1 (wraps at 2^CNT_W). Next state FETCH if run_i, else IDLE.
//  - Wait counter: increments each FETCH/MEM cycle with mem_ready_i=0; clears on ready or state change.
//    When it reaches TIMEOUT with ready still 0 -> TRAP and set timeout_o. Ready on that same cycle wins.
//  - TRAP: all control outputs 0. clr_i=1 -> IDLE and clears illegal_o/timeout_o. Otherwise hold.
//  - run_i deasserted mid-instruction: the instruction still completes.
//  - Async reset mid-MEM: mem_read/mem_write drop immediately; no retire.
// TESTING
//  - Reset, run_i=1, R-type, mem_ready_i=1 -> states 1,2,3,5.
//    reg_write and reg_dst=1 in WB; instr_done pulse; instr_cnt_o=1.
//  - LHU (25), fetch ready after 2 waits, MEM ready immediately -> FETCH lasts 3 cycles.
//    MEM: mem_read=1, i_or_d=1, mem_num=10, unsigned=1. WB: mem_to_reg=1.
//  - SB (28) -> MEM mem_write=1, mem_num=01, no WB, done after MEM. BEQ (04) -> EXEC branch_o=1, alu_op=0D, 3 cycles.
//  - Opcode 3F -> TRAP, illegal_o=1, outputs 0. clr_i -> IDLE and flags clear; instr_cnt_o unchanged.
//  - TIMEOUT=4, mem_ready_i held 0 in FETCH -> TRAP after 4 wait cycles with timeout_o=1.
//    Repeat with ready on the 4th cycle -> no trap.
//  - run_i dropped during EXEC of JAL -> WB with link_o=1, then IDLE.
//    rst_n_i pulsed in MEM -> IDLE asynchronously, all outputs 0.

Source files
------------

// File: rtl/multicycle_ctrl_fsm.sv
// -----------------------------------------------------------------------------
// multicycle_ctrl_fsm
//
// Multi-cycle control unit for the R3000 core. It steps each instruction
// through FETCH / DECODE / EXEC / MEM / WB and stalls in FETCH and MEM until the
// memory port signals ready. It also provides:
//   - a memory-wait timeout that traps,
//   - an undefined-opcode trap,
//   - a counter of retired instructions.
// The unit sits between the instruction register / memory port and the shared
// single-ALU datapath.
//
// Ports
//   clk_i, rst_n_i        clock (rising edge), asynchronous active-low reset
//   run_i                 keep issuing; sampled only in IDLE and when an
//                         instruction retires
//   clr_i                 leave TRAP and clear the sticky flags
//   instr_op_i[5:0]       IR opcode field, latched in DECODE
//   mem_ready_i           memory completes the current access this cycle
//   pc_write_o .. unsigned_o
//                         datapath controls. They are decoded from the state
//                         and the latched opcode. The one exception is FETCH,
//                         where ir_write_o / pc_write_o follow mem_ready_i.
//   state_o[2:0]          IDLE=0 FETCH=1 DECODE=2 EXEC=3 MEM=4 WB=5 TRAP=6
//   instr_done_o          one-cycle pulse, issued together with the
//                         instr_cnt_o update, in the cycle after retirement
//   illegal_o, timeout_o  sticky trap causes
//   instr_cnt_o           retired-instruction count (wraps)
// -----------------------------------------------------------------------------
module multicycle_ctrl_fsm #(
    parameter int ALU_OP_W = 5,
    parameter int TIMEOUT  = 255,
    parameter int CNT_W    = 32
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    input  logic                run_i,
    input  logic                clr_i,
    input  logic [5:0]          instr_op_i,
    input  logic                mem_ready_i,
    output logic                pc_write_o,
    output logic                ir_write_o,
    output logic                i_or_d_o,
    output logic                mem_read_o,
    output logic                mem_write_o,
    output logic                reg_write_o,
    output logic                reg_dst_o,
    output logic                mem_to_reg_o,
    output logic                link_o,
    output logic                alu_src_a_o,
    output logic [1:0]          alu_src_b_o,
    output logic [ALU_OP_W-1:0] alu_op_o,
    output logic                branch_o,
    output logic                jump_o,
    output logic [1:0]          mem_num_o,
    output logic                unsigned_o,
    output logic [2:0]          state_o,
    output logic                instr_done_o,
    output logic                illegal_o,
    output logic                timeout_o,
    output logic [CNT_W-1:0]    instr_cnt_o
);

    // The wait counter only counts up to TIMEOUT-1. The cycle that would make
    // it reach TIMEOUT traps instead of incrementing.
    localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_TRAP   = 3'd6
    } state_e;

    // K_RTYPE is encoded as zero. As a result, the all-zero reset value of the
    // decode latch is the decode of opcode 00.
    typedef enum logic [2:0] {
        K_RTYPE, K_IMM, K_LOAD, K_STORE, K_BRANCH, K_JUMP, K_JAL, K_ILLEGAL
    } kind_e;

    typedef struct packed {
        kind_e      kind;
        logic [4:0] alu;
        logic [1:0] num;
        logic       uns;
    } dec_t;

    localparam logic [4:0] ALU_NOTH = 5'h00, ALU_ADD = 5'h01, ALU_ADDU = 5'h02,
                           ALU_AND  = 5'h04, ALU_OR  = 5'h05, ALU_NOR  = 5'h07,
                           ALU_SLT  = 5'h09, ALU_EQ  = 5'h0D, ALU_NEQ  = 5'h0E,
                           ALU_GT   = 5'h0F, ALU_JTYP = 5'h10, ALU_LUI = 5'h11;

    localparam logic [1:0] SZ_B = 2'b01, SZ_H = 2'b10, SZ_W = 2'b11;

    function automatic dec_t mk(input kind_e k, input logic [4:0] a,
                                input logic [1:0] n, input logic u);
        dec_t d;
        d.kind = k;
        d.alu  = a;
        d.num  = n;
        d.uns  = u;
        return d;
    endfunction

    function automatic dec_t decode_op(input logic [5:0] op);
        dec_t d;
        case (op)
            6'h00:   d = mk(K_RTYPE,  ALU_NOTH, 2'b00, 1'b0);
            6'h08:   d = mk(K_IMM,    ALU_ADD,  2'b00, 1'b0);
            6'h09:   d = mk(K_IMM,    ALU_ADDU, 2'b00, 1'b1);
            6'h0C:   d = mk(K_IMM,    ALU_AND,  2'b00, 1'b0);
            6'h0D:   d = mk(K_IMM,    ALU_OR,   2'b00, 1'b0);
            6'h0E:   d = mk(K_IMM,    ALU_NOR,  2'b00, 1'b0);
            6'h0A:   d = mk(K_IMM,    ALU_SLT,  2'b00, 1'b0);
            6'h0F:   d = mk(K_IMM,    ALU_LUI,  2'b00, 1'b0);
            6'h23:   d = mk(K_LOAD,   ALU_ADD,  SZ_W,  1'b0);
            6'h21:   d = mk(K_LOAD,   ALU_ADD,  SZ_H,  1'b0);
            6'h25:   d = mk(K_LOAD,   ALU_ADD,  SZ_H,  1'b1);
            6'h20:   d = mk(K_LOAD,   ALU_ADD,  SZ_B,  1'b0);
            6'h24:   d = mk(K_LOAD,   ALU_ADD,  SZ_B,  1'b1);
            6'h2B:   d = mk(K_STORE,  ALU_ADD,  SZ_W,  1'b0);
            6'h29:   d = mk(K_STORE,  ALU_ADD,  SZ_H,  1'b0);
            6'h28:   d = mk(K_STORE,  ALU_ADD,  SZ_B,  1'b0);
            6'h04:   d = mk(K_BRANCH, ALU_EQ,   2'b00, 1'b0);
            6'h05:   d = mk(K_BRANCH, ALU_NEQ,  2'b00, 1'b0);
            6'h07:   d = mk(K_BRANCH, ALU_GT,   2'b00, 1'b0);
            6'h02:   d = mk(K_JUMP,   ALU_JTYP, 2'b00, 1'b0);
            6'h03:   d = mk(K_JAL,    ALU_JTYP, 2'b00, 1'b0);
            default: d = mk(K_ILLEGAL, ALU_NOTH, 2'b00, 1'b0);
        endcase
        return d;
    endfunction

    state_e            state_q, state_d;
    dec_t              dec_q, dec_d;
    dec_t              dec_in;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              illegal_q, illegal_d;
    logic              timeout_q, timeout_d;
    logic [CNT_W-1:0]  cnt_q;
    logic              done_q;
    logic              retire;
    logic [4:0]        alu_code;

    // The full decode record is latched rather than the raw opcode, so that
    // EXEC/MEM/WB read their controls directly from registers.
    assign dec_in = decode_op(instr_op_i);

    // NOTE: the state register uses non-blocking assignments so that every flop
    // samples the pre-edge values, whatever order the blocks are evaluated in.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= S_IDLE;
            dec_q     <= '0;
            wait_q    <= '0;
            illegal_q <= 1'b0;
            timeout_q <= 1'b0;
            cnt_q     <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            dec_q     <= dec_d;
            wait_q    <= wait_d;
            illegal_q <= illegal_d;
            timeout_q <= timeout_d;
            cnt_q     <= cnt_q + CNT_W'(retire);
            done_q    <= retire;
        end
    end

    // NOTE: every output of this block gets a default before the case. Without
    // that, any path that leaves one unassigned infers a latch.
    always_comb begin
        state_d      = state_q;
        dec_d        = dec_q;
        wait_d       = '0;
        illegal_d    = illegal_q;
        timeout_d    = timeout_q;
        retire       = 1'b0;
        alu_code     = ALU_NOTH;
        pc_write_o   = 1'b0;
        ir_write_o   = 1'b0;
        i_or_d_o     = 1'b0;
        mem_read_o   = 1'b0;
        mem_write_o  = 1'b0;
        reg_write_o  = 1'b0;
        reg_dst_o    = 1'b0;
        mem_to_reg_o = 1'b0;
        link_o       = 1'b0;
        alu_src_a_o  = 1'b0;
        alu_src_b_o  = 2'b00;
        branch_o     = 1'b0;
        jump_o       = 1'b0;
        mem_num_o    = 2'b00;
        unsigned_o   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (run_i) state_d = S_FETCH;
            end

            S_FETCH: begin
                mem_read_o  = 1'b1;
                alu_src_b_o = 2'b01;
                alu_code    = ALU_ADDU;
                // A ready on the last allowed cycle still wins over the trap.
                if (mem_ready_i) begin
                    ir_write_o = 1'b1;
                    pc_write_o = 1'b1;
                    state_d    = S_DECODE;
                end else if (wait_q == WAIT_LAST) begin
                    state_d   = S_TRAP;
                    timeout_d = 1'b1;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end

            S_DECODE: begin
                dec_d = dec_in;
                if (dec_in.kind == K_ILLEGAL) begin
                    state_d   = S_TRAP;
                    illegal_d = 1'b1;
                end else begin
                    state_d = S_EXEC;
                end
            end

            S_EXEC: begin
                alu_src_a_o = 1'b1;
                alu_code    = dec_q.alu;
                case (dec_q.kind)
                    K_RTYPE: begin
                        reg_dst_o = 1'b1;
                        state_d   = S_WB;
                    end
                    K_IMM: begin
                        alu_src_b_o = 2'b10;
                        unsigned_o  = dec_q.uns;
                        state_d     = S_WB;
                    end
                    K_LOAD, K_STORE: begin
                        alu_src_b_o = 2'b10;
                        mem_num_o   = dec_q.num;
                        unsigned_o  = dec_q.uns;
                        state_d     = S_MEM;
                    end
                    K_BRANCH: begin
                        branch_o = 1'b1;
                        retire   = 1'b1;
                    end
                    K_JUMP: begin
                        jump_o     = 1'b1;
                        pc_write_o = 1'b1;
                        retire     = 1'b1;
                    end
                    K_JAL: begin
                        jump_o     = 1'b1;
                        pc_write_o = 1'b1;
                        state_d    = S_WB;
                    end
                    default: state_d = S_TRAP;
                endcase
            end

            S_MEM: begin
                i_or_d_o    = 1'b1;
                mem_read_o  = (dec_q.kind == K_LOAD);
                mem_write_o = (dec_q.kind == K_STORE);
                mem_num_o   = dec_q.num;
                unsigned_o  = dec_q.uns;
                if (mem_ready_i) begin
                    if (dec_q.kind == K_LOAD) state_d = S_WB;
                    else                      retire  = 1'b1;
                end else if (wait_q == WAIT_LAST) begin
                    state_d   = S_TRAP;
                    timeout_d = 1'b1;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end

            S_WB: begin
                reg_write_o  = 1'b1;
                mem_to_reg_o = (dec_q.kind == K_LOAD);
                reg_dst_o    = (dec_q.kind == K_RTYPE);
                link_o       = (dec_q.kind == K_JAL);
                retire       = 1'b1;
            end

            S_TRAP: begin
                if (clr_i) begin
                    state_d   = S_IDLE;
                    illegal_d = 1'b0;
                    timeout_d = 1'b0;
                end
            end

            default: state_d = S_IDLE;
        endcase

        // run_i is sampled here only, so dropping it mid-instruction does not
        // cut the instruction short.
        if (retire) state_d = run_i ? S_FETCH : S_IDLE;
    end

    assign alu_op_o     = ALU_OP_W'(alu_code);
    assign state_o      = state_q;
    assign instr_done_o = done_q;
    assign illegal_o    = illegal_q;
    assign timeout_o    = timeout_q;
    assign instr_cnt_o  = cnt_q;

endmodule
